input_skew_feeder: RTL and testbench

- Read-side sequencer for the per-row input SRAM bank array (SYS_ROW banks, 16-bit x 256 words, 1-cycle read latency).
- Generates per-row rd_en/rd_addr with a one-cycle diagonal skew per row, so row i trails row i-1 by one cycle.
- Drives the skewed, valid-tagged operand streams into the systolic array's left edge.
- Supports array-side stall and start/busy/done control from the layer controller.

---
 rtl/input_skew_feeder.sv | 133 +++++++++++++
 tb/tb_input_skew_feeder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_skew_feeder.sv
// input_skew_feeder: read-side sequencer for the per-row input SRAM banks.
// Issues diagonally skewed reads (row i trails row i-1 by one cycle) and
// turns the 1-cycle-latency bank data into valid-tagged operand streams for
// the left edge of the systolic array. A stall freezes the whole feeder.
module input_skew_feeder #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [ADDR_WIDTH-1:0]                 base_addr,
  input  logic [ADDR_WIDTH-1:0]                 len,
  input  logic                                  stall,
  output logic                                  busy,
  output logic                                  done,
  output logic [SYS_ROW-1:0]                    rd_en,
  output logic [SYS_ROW-1:0][ADDR_WIDTH-1:0]    rd_addr,
  input  logic [SYS_ROW-1:0][DATA_WIDTH-1:0]    rd_data,
  output logic [SYS_ROW-1:0]                    arr_valid,
  output logic [SYS_ROW-1:0][DATA_WIDTH-1:0]    arr_data
);

  // One extra bit over the address width covers the skew tail
  // (the counter runs up to len + SYS_ROW - 2).
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [SYS_ROW-1:0]      pending_q;
  logic [SYS_ROW-1:0]      pending_d;
  logic [CNT_W-1:0]        last_cnt;

  // Counter value at which the last row issues its last read.
  assign last_cnt = {1'b0, len_q} + CNT_W'(SYS_ROW - 2);

  // Job sequencer: start is taken only in IDLE; every later state advances
  // only on non-stalled cycles so a stall freezes the job exactly in place.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            len_q   <= len;
            cnt_q   <= '0;
            state_q <= (len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            if (cnt_q == last_cnt) begin
              state_q <= ST_FLUSH;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (!stall) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!stall) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Diagonal read window: row i reads while i <= c < i + len, at address
  // base + c - i; the 8-bit subtraction wraps past 255 back to 0.
  always_comb begin
    rd_en   = '0;
    rd_addr = '0;
    if ((state_q == ST_RUN) && !stall) begin
      for (int i = 0; i < SYS_ROW; i++) begin
        if ((cnt_q >= CNT_W'(i)) && (cnt_q < (CNT_W'(i) + {1'b0, len_q}))) begin
          rd_en[i]   = 1'b1;
          rd_addr[i] = base_q + cnt_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(i);
        end
      end
    end
  end

  // A read issued this cycle has data next cycle; a stall holds the marker
  // so the bank's held output is presented on the release cycle.
  always_comb begin
    pending_d = stall ? pending_q : rd_en;
  end

  // Registered read-in-flight markers, one per row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Operand presentation: data is forced to zero whenever its valid is low.
  always_comb begin
    arr_valid = pending_q & ~{SYS_ROW{stall}};
    arr_data  = '0;
    for (int i = 0; i < SYS_ROW; i++) begin
      if (arr_valid[i]) begin
        arr_data[i] = rd_data[i];
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE) && !stall;

endmodule

// File: tb/tb_input_skew_feeder.sv
// Testbench for input_skew_feeder: a bank-array model answers the reads,
// stimulus pushes each row's expected operand stream into a scoreboard, and
// a negedge monitor checks both the streams and the cycle-level timing.
module tb_input_skew_feeder;

  localparam int SYS_ROW = 16;
  localparam int DW      = 16;
  localparam int AW      = 8;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic                          start;
  logic [AW-1:0]                 baseAddr;
  logic [AW-1:0]                 lenIn;
  logic                          stall;
  logic                          busy;
  logic                          done;
  logic [SYS_ROW-1:0]            rdEn;
  logic [SYS_ROW-1:0][AW-1:0]    rdAddr;
  logic [SYS_ROW-1:0][DW-1:0]    rdData = '0;
  logic [SYS_ROW-1:0]            arrValid;
  logic [SYS_ROW-1:0][DW-1:0]    arrData;

  logic [DW-1:0] mem [SYS_ROW][256];
  logic [DW-1:0] expQ [SYS_ROW][$];

  int testsRun    = 0;
  int testsFailed = 0;

  // Job bookkeeping shared between stimulus and monitor.
  bit jobStart  = 1'b0;
  bit jobActive = 1'b0;
  int jobBase   = 0;
  int jobLen    = 0;
  int eff       = 0;

  input_skew_feeder #(
    .SYS_ROW   (SYS_ROW),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .base_addr(baseAddr),
    .len      (lenIn),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .rd_en    (rdEn),
    .rd_addr  (rdAddr),
    .rd_data  (rdData),
    .arr_valid(arrValid),
    .arr_data (arrData)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Fill every bank with random words before the first read.
  initial begin
    for (int r = 0; r < SYS_ROW; r++) begin
      for (int a = 0; a < 256; a++) begin
        mem[r][a] = DW'($urandom);
      end
    end
  end

  // Bank array model: 1-cycle read latency, output held while enable is low.
  always @(posedge clk) begin
    for (int r = 0; r < SYS_ROW; r++) begin
      if (rdEn[r]) begin
        rdData[r] <= mem[r][rdAddr[r]];
      end
    end
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor. A stalled cycle must show nothing but busy; dropping those
  // cycles leaves the unstalled trace, where at job cycle e (c = e-1) row i
  // reads base+c-i while i <= c < i+len, its operand is valid for
  // i+2 <= e <= i+len+1, and done falls at e = len+SYS_ROW+1 (e = 1 if empty).
  always @(negedge clk) begin : monitor
    logic [SYS_ROW-1:0]         expEn;
    logic [SYS_ROW-1:0][AW-1:0] expAddr;
    logic [SYS_ROW-1:0]         expValid;
    int cIdx;
    int doneEff;
    if (!rstn) begin
      jobActive = 1'b0;
      jobStart  = 1'b0;
      for (int r = 0; r < SYS_ROW; r++) expQ[r].delete();
      checkOutput("resetCtrl", 256'({busy, done, rdEn, arrValid}), 256'(0));
      checkOutput("resetAddr", 256'(rdAddr), 256'(0));
      checkOutput("resetData", 256'(arrData), 256'(0));
    end else begin
      expEn    = '0;
      expAddr  = '0;
      expValid = '0;
      if (jobActive && !stall) begin
        cIdx    = eff - 1;
        doneEff = (jobLen == 0) ? 1 : jobLen + SYS_ROW + 1;
        for (int r = 0; r < SYS_ROW; r++) begin
          if (cIdx >= r && cIdx < r + jobLen) begin
            expEn[r]   = 1'b1;
            expAddr[r] = AW'(jobBase + cIdx - r);
          end
          if (eff >= r + 2 && eff <= r + jobLen + 1) expValid[r] = 1'b1;
        end
        checkOutput("rdEn", 256'(rdEn), 256'(expEn));
        checkOutput("rdAddr", 256'(rdAddr), 256'(expAddr));
        checkOutput("arrValid", 256'(arrValid), 256'(expValid));
        checkOutput("done", 256'(done), 256'(eff == doneEff));
        checkOutput("busy", 256'(busy), 256'(1));
      end else begin
        checkOutput("quietCtrl", 256'({done, rdEn, arrValid}), 256'(0));
        checkOutput("quietAddr", 256'(rdAddr), 256'(0));
        checkOutput("busy", 256'(busy), 256'(jobActive));
      end
      // Scoreboard: every presented operand pops the row's expected stream.
      for (int r = 0; r < SYS_ROW; r++) begin
        if (arrValid[r]) begin
          checkOutput($sformatf("row%0dHasExpected", r), 256'(expQ[r].size() > 0), 256'(1));
          if (expQ[r].size() > 0) begin
            checkOutput($sformatf("row%0dData", r), 256'(arrData[r]), 256'(expQ[r].pop_front()));
          end
        end else begin
          checkOutput($sformatf("row%0dIdleZero", r), 256'(arrData[r]), 256'(0));
        end
      end
      if (jobActive && !stall) begin
        if (eff == ((jobLen == 0) ? 1 : jobLen + SYS_ROW + 1)) begin
          jobActive = 1'b0;
          for (int r = 0; r < SYS_ROW; r++) begin
            checkOutput($sformatf("row%0dLeftover", r), 256'(expQ[r].size()), 256'(0));
          end
        end
        eff++;
      end
      if (jobStart) begin
        jobStart  = 1'b0;
        jobActive = 1'b1;
        eff       = 1;
      end
    end
  end

  // Run one job: start pulse, optional stall window and optional extra
  // (ignored) start pulse, each given in cycles after the accepted start.
  task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW-1:0] l,
                               input int stallAt, input int stallLen, input int extraAt);
    bit seen;
    int budget;
    seen   = 1'b0;
    budget = int'(l) + SYS_ROW + stallLen + 6;
    @(posedge clk); #1;
    start    = 1'b1;
    baseAddr = b;
    lenIn    = l;
    jobBase  = int'(b);
    jobLen   = int'(l);
    for (int r = 0; r < SYS_ROW; r++) begin
      for (int k = 0; k < int'(l); k++) begin
        expQ[r].push_back(mem[r][AW'(int'(b) + k)]);
      end
    end
    jobStart = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start = (k == extraAt);
      if (start) begin
        baseAddr = AW'($urandom);
        lenIn    = AW'($urandom_range(1, 255));
      end
      stall = (stallAt != 0) && (k >= stallAt) && (k < stallAt + stallLen);
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    checkOutput("doneSeen", 256'(seen), 256'(1));
  endtask

  // Abort a job with an asynchronous reset while the counter sits at 5.
  task automatic resetMidJob(input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(posedge clk); #1;
    start    = 1'b1;
    baseAddr = b;
    lenIn    = l;
    jobBase  = int'(b);
    jobLen   = int'(l);
    for (int r = 0; r < SYS_ROW; r++) begin
      for (int k = 0; k < int'(l); k++) begin
        expQ[r].push_back(mem[r][AW'(int'(b) + k)]);
      end
    end
    jobStart = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #1 rstn = 1'b0;
    #1;
    checkOutput("asyncResetCtrl", 256'({busy, done, rdEn, arrValid}), 256'(0));
    checkOutput("asyncResetAddr", 256'(rdAddr), 256'(0));
    checkOutput("asyncResetData", 256'(arrData), 256'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Directed scenarios first, then randomized jobs.
  initial begin
    int l;
    int sAt;
    int sLen;
    rstn     = 1'b0;
    start    = 1'b0;
    stall    = 1'b0;
    baseAddr = '0;
    lenIn    = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus(8'h10, 8'd3, 0, 0, 2);
    applyStimulus(8'hFE, 8'd4, 0, 0, 0);
    applyStimulus(8'h40, 8'd6, 5, 3, 0);
    applyStimulus(8'h33, 8'd0, 0, 0, 1);
    applyStimulus(8'h80, 8'd5, 0, 0, 0);
    resetMidJob(8'h20, 8'd8);
    applyStimulus(8'h21, 8'd7, 0, 0, 0);
    applyStimulus(8'hF0, 8'd255, 100, 2, 0);

    for (int n = 0; n < 25; n++) begin
      l    = $urandom_range(0, 20);
      sAt  = 0;
      sLen = 0;
      if ($urandom_range(0, 1) == 1) begin
        sAt  = $urandom_range(1, l + SYS_ROW);
        sLen = $urandom_range(1, 4);
      end
      applyStimulus(AW'($urandom), AW'(l), sAt, sLen, int'($urandom_range(0, 8)));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
